// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and small decode helpers
// used by the timing generator and the downstream draw stages.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int HS_START_DEF  = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int HS_END_DEF    = HS_START_DEF + H_SYNC_DEF;
    localparam int VS_START_DEF  = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int VS_END_DEF    = VS_START_DEF + V_SYNC_DEF;

    // Compare in 32-bit so an end bound equal to 1024 still works.
    function automatic logic in_window(coord_t value, int lo, int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

    function automatic logic sync_level(logic in_pulse, logic active_level);
        return in_pulse ? active_level : ~active_level;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Bundle of timing outputs handed from the timing generator to the draw stages.
interface vga_timing_if
    import vga_timing_pkg::*;
#(
    parameter int FCNT_W = 8
);
    logic              hs;
    logic              vs;
    logic              blank;
    coord_t            DrawX;
    coord_t            DrawY;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_count;

    modport master (
        output hs, vs, blank, DrawX, DrawY, frame_start, frame_count
    );

    modport slave (
        input hs, vs, blank, DrawX, DrawY, frame_start, frame_count
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..MAX-1 while enabled and flags the wrapping clock.
// count_next exposes the value the counter takes at the next edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = 800
)(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   enable,
    output coord_t count,
    output coord_t count_next,
    output logic   wrap
);

    if (MAX > 1024 || MAX < 1) begin : g_bad_max
        $error("vga_axis_counter: MAX must lie in 1..1024");
    end

    localparam coord_t LAST = coord_t'(MAX - 1);

    coord_t count_q;
    coord_t count_d;
    logic   at_last;

    always_comb begin
        at_last = (count_q == LAST);
        wrap    = enable && at_last;
        count_d = count_q;
        if (enable) begin
            count_d = at_last ? '0 : count_q + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: two axis counters plus registered sync/blank/frame flags,
// decoded from next-state coordinates so flags line up with DrawX/DrawY.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = H_VISIBLE_DEF,
    parameter int   H_FRONT     = H_FRONT_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BACK      = H_BACK_DEF,
    parameter int   V_VISIBLE   = V_VISIBLE_DEF,
    parameter int   V_FRONT     = V_FRONT_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BACK      = V_BACK_DEF,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   FCNT_W      = 8
)(
    input  logic            vga_clk,
    input  logic            reset_n,
    vga_timing_if.master    vga
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    coord_t x_count, x_next;
    coord_t y_count, y_next;
    logic   h_wrap, v_wrap;

    vga_axis_counter #(.MAX(H_TOTAL)) u_h_counter (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .enable     (1'b1),
        .count      (x_count),
        .count_next (x_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(.MAX(V_TOTAL)) u_v_counter (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .enable     (h_wrap),
        .count      (y_count),
        .count_next (y_next),
        .wrap       (v_wrap)
    );

    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              blank_q, blank_d;
    logic              frame_start_q, frame_start_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;

    // Only a full raster wrap counts as a frame, so the partial frame after reset is ignored.
    always_comb begin
        hs_d          = sync_level(in_window(x_next, HS_START, HS_END), SYNC_ACTIVE);
        vs_d          = sync_level(in_window(y_next, VS_START, VS_END), SYNC_ACTIVE);
        blank_d       = in_window(x_next, 0, H_VISIBLE) && in_window(y_next, 0, V_VISIBLE);
        frame_start_d = h_wrap && v_wrap;
        frame_count_d = frame_count_q;
        if (frame_start_d) begin
            frame_count_d = frame_count_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q          <= ~SYNC_ACTIVE;
            vs_q          <= ~SYNC_ACTIVE;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.blank       = blank_q;
    assign vga.DrawX       = x_count;
    assign vga.DrawY       = y_count;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;

endmodule
